// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, then executes the access and returns a single-cycle response.
// Byte/half/word accesses with RV32I sign/zero extension; misaligned,
// illegal-code and out-of-range accesses return a fault and touch nothing.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only while idle, so the requester must hold req_valid and
// its fields stable until that edge. The response has no backpressure:
// resp_valid pulses for one cycle; resp_rdata/resp_fault hold until the next one.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [1:0]  dbg_state
);

  localparam int         IDXW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        q_we;
  logic [2:0]  q_f3;
  logic [31:0] q_addr;
  logic [31:0] q_wdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        exec;
  logic        a_we;
  logic [2:0]  a_f3;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;

  logic            is_byte, is_half, is_word, sign, bad_code, misalign, oob, fault;
  logic [IDXW-1:0] widx;
  logic [31:0]     rword, ldata, wmask, wdata_rep, wword;
  logic [7:0]      lbyte;
  logic [15:0]     lhalf;

  assign accept    = req_valid && req_ready;
  // The access runs on the edge that enters RESP.
  assign exec      = ((state == S_IDLE) && accept && (LATENCY == 0)) ||
                     ((state == S_WAIT) && (cnt == 4'd0));
  assign dbg_state = state;

  // With zero latency the access executes on the accept edge, so it must see
  // the live request rather than the not-yet-captured copy.
  always_comb begin
    a_we    = q_we;
    a_f3    = q_f3;
    a_addr  = q_addr;
    a_wdata = q_wdata;
    if (state == S_IDLE) begin
      a_we    = req_we;
      a_f3    = req_funct3;
      a_addr  = req_addr;
      a_wdata = req_wdata;
    end
  end

  // Decode width/sign, detect faults, build load result and merged store word.
  always_comb begin
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    sign     = 1'b0;
    bad_code = 1'b0;
    case (a_f3)
      3'b000:  begin is_byte = 1'b1; sign = 1'b1; end
      3'b001:  begin is_half = 1'b1; sign = 1'b1; end
      3'b010:  is_word = 1'b1;
      3'b100:  begin is_byte = 1'b1; bad_code = a_we; end
      3'b101:  begin is_half = 1'b1; bad_code = a_we; end
      default: bad_code = 1'b1;
    endcase
    misalign = (is_half && a_addr[0]) || (is_word && (a_addr[1:0] != 2'b00));
    oob      = {2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS);
    fault    = bad_code || misalign || oob;

    widx  = a_addr[IDXW+1:2];
    rword = mem[widx];
    lbyte = rword[{a_addr[1:0], 3'b000} +: 8];
    lhalf = a_addr[1] ? rword[31:16] : rword[15:0];
    if (is_byte)      ldata = {{24{sign & lbyte[7]}}, lbyte};
    else if (is_half) ldata = {{16{sign & lhalf[15]}}, lhalf};
    else              ldata = rword;

    if (is_byte) begin
      wmask     = 32'h0000_00FF << {a_addr[1:0], 3'b000};
      wdata_rep = {4{a_wdata[7:0]}};
    end else if (is_half) begin
      wmask     = a_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      wdata_rep = {2{a_wdata[15:0]}};
    end else begin
      wmask     = 32'hFFFF_FFFF;
      wdata_rep = a_wdata;
    end
    wword = (rword & ~wmask) | (wdata_rep & wmask);
  end

  // Storage write: only legal stores, never while reset is held.
  always_ff @(posedge clk) begin
    if (!reset && exec && a_we && !fault) mem[widx] <= wword;
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_fault <= 1'b0;
      q_we       <= 1'b0;
      q_f3       <= 3'b000;
      q_addr     <= 32'h0;
      q_wdata    <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            q_we      <= req_we;
            q_f3      <= req_funct3;
            q_addr    <= req_addr;
            q_wdata   <= req_wdata;
            req_ready <= 1'b0;
            cnt       <= WAIT_LOAD;
            state     <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
      if (exec) begin
        resp_valid <= 1'b1;
        resp_fault <= fault;
        resp_rdata <= (fault || a_we) ? 32'h0 : ldata;
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core: the memory-side end of the core's load/store port, which carries address = ALUResult, store data = WriteData and load data returned as ReadData. It accepts one load or store request at a time over a valid/ready handshake and inserts a programmable number of wait states. It performs byte/halfword/word accesses with RV32I sign/zero extension. Misaligned, unsupported and out-of-range accesses are returned as faults instead of being executed.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words of storage; word index = req_addr[31:2].
- LATENCY, 2: wait cycles between acceptance and response; legal range 0..15.

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result, extended to 32 bits; 0 on stores and faults
- resp_fault  out  1  qualifies resp_valid; access was not performed

## Operation
- Request capture:
  - A request is accepted on a cycle where req_valid && req_ready.
  - req_we, req_funct3, req_addr and req_wdata are registered at acceptance.
  - Inputs are ignored at all other times.
- States:
  - IDLE: req_ready=1. On acceptance, go to WAIT if LATENCY>0, else go to RESP.
  - WAIT: down-counter loaded with LATENCY-1 at acceptance. Go to RESP when the counter reaches 0; otherwise decrement.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- The access executes on the edge that enters RESP:
  - Stores write memory on that edge.
  - Load data and fault status are registered on that edge.
- Decode for loads (req_we=0):
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended half.
  - 011, 110, 111: fault.
- Decode for stores (req_we=1):
  - 000 SB, 001 SH, 010 SW.
  - Any other code: fault.
- Lane selection:
  - Byte lane = addr[1:0].
  - Half lane = addr[1].
  - Stores modify only the addressed byte lanes; the other bytes of the word are unchanged.
- Faults set resp_fault=1, force resp_rdata=0 and perform no write. A request faults if any of:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - illegal funct3 code;
  - addr[31:2] ≥ DEPTH_WORDS.
- Stores respond with resp_rdata=0 and resp_fault=0 when legal.
- Memory is little-endian, uninitialised and not cleared by reset.
- Ordering: a load accepted after a store's response observes the stored data.

## Timing
- Latency: a request accepted at rising edge N produces resp_valid high in cycle N+1+LATENCY.
  - LATENCY=0 → response in the cycle immediately after acceptance.
- Throughput: one request per LATENCY+2 cycles.
  - req_ready is low from acceptance through the RESP cycle.
  - req_ready returns high the cycle after RESP.
- No response backpressure: the consumer must sample resp_* while resp_valid=1.
  - resp_rdata and resp_fault hold their values until the next response.
- Asynchronous reset:
  - Forces IDLE immediately: req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, counter=0.
  - An in-flight request (in WAIT or at RESP entry) is discarded; its store is not performed and no response is issued.
- Simultaneous events:
  - req_valid during WAIT or RESP is not accepted; the requester must hold the request until req_ready.
  - req_valid in the first IDLE cycle after RESP is accepted.
- Address wrap: there is none. Out-of-range addresses fault; the index is never truncated.

## Test plan
- Basic store/load, LATENCY=2:
  - SW 0xDEADBEEF to 0x10 → resp_valid 3 cycles after accept, fault=0, rdata=0.
  - LW 0x10 → rdata=0xDEADBEEF.
- Byte lanes and extension:
  - SB 0x80 to 0x13 over word 0x11223344 → LW 0x10 = 0x80223344.
  - LB 0x13 = 0xFFFFFF80.
  - LBU 0x13 = 0x00000080.
- Halfword:
  - SH 0xBEEF to 0x22 → LHU 0x22 = 0x0000BEEF.
  - LH 0x22 = 0xFFFFBEEF.
- Faults, each giving resp_fault=1, rdata=0 and memory unchanged:
  - LW 0x11;
  - SH 0x21;
  - funct3 011 load;
  - SW to byte address 4*DEPTH_WORDS.
- Reset mid-operation:
  - Accept SW 0x12345678 to 0x30, assert reset during WAIT → no resp_valid.
  - After release, LW 0x30 returns the old contents; req_ready=1 immediately during reset.
- Handshake and LATENCY=0:
  - req_valid held high continuously → accepts every 2 cycles, resp_valid pulses one cycle each.
  - Requests presented while req_ready=0 are not consumed early.
